// File: rtl/morse_rx.sv
// morse_rx: Morse-code receiver decoding letters A..H to a 3-bit code.
// Samples the keyed line once per time unit, measures mark/space run
// lengths, classifies marks as dot/dash and decodes on a letter gap.
// Optional feature: define MORSE_RX_SYNC_EN to pass the line through a
// 2-flop synchroniser (adds 2 clk cycles of latency to every decode event).
module morse_rx #(
    parameter int UNIT_CYCLES = 1,
    parameter int DASH_MIN    = 2,
    parameter int GAP_UNITS   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       line,
    output logic [2:0] letter,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    localparam int             PW       = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(UNIT_CYCLES - 1);
    localparam logic [2:0]     DASH_RUN = 3'(DASH_MIN);
    localparam logic [2:0]     GAP_RUN  = 3'(GAP_UNITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    logic          line_s;
    logic          tick;
    logic [PW-1:0] pre_q, pre_d;
    state_t        state_q, state_d;
    logic [2:0]    run_q, run_d;
    logic [3:0]    pattern_q, pattern_d;
    logic [2:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [2:0]    letter_q, letter_d;
    logic          error_q, error_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;

`ifdef MORSE_RX_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-stage synchroniser for an asynchronous keyed line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= line;
            sync2_q <= sync1_q;
        end
    end

    assign line_s = sync2_q;
`else
    assign line_s = line;
`endif

    // Pattern/count/overflow to letter code; anything else is an error.
    function automatic logic [3:0] lookup(input logic [2:0] cnt,
                                          input logic [3:0] pat,
                                          input logic       ovf);
        logic [3:0] res;
        res = {3'd0, 1'b1};
        if (!ovf) begin
            case ({cnt, pat})
                {3'd2, 4'b0001}: res = {3'd0, 1'b0}; // A .-
                {3'd4, 4'b1000}: res = {3'd1, 1'b0}; // B -...
                {3'd4, 4'b1010}: res = {3'd2, 1'b0}; // C -.-.
                {3'd3, 4'b0100}: res = {3'd3, 1'b0}; // D -..
                {3'd1, 4'b0000}: res = {3'd4, 1'b0}; // E .
                {3'd4, 4'b0010}: res = {3'd5, 1'b0}; // F ..-.
                {3'd3, 4'b0110}: res = {3'd6, 1'b0}; // G --.
                {3'd4, 4'b0000}: res = {3'd7, 1'b0}; // H ....
                default:         res = {3'd0, 1'b1};
            endcase
        end
        return res;
    endfunction

    function automatic logic [2:0] sat_inc7(input logic [2:0] v);
        return (v == 3'd7) ? 3'd7 : v + 3'd1;
    endfunction

    assign tick = (pre_q == PRE_LAST);

    // Next-state logic: prescaler, run-length measurement and letter FSM.
    always_comb begin
        pre_d     = tick ? '0 : pre_q + 1'b1;
        state_d   = state_q;
        run_d     = run_q;
        pattern_d = pattern_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        letter_d  = letter_q;
        error_d   = error_q;
        valid_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick && line_s) begin
                    state_d   = S_MARK;
                    run_d     = 3'd1;
                    pattern_d = 4'd0;
                    count_d   = 3'd0;
                    ovf_d     = 1'b0;
                end
            end
            S_MARK: begin
                if (tick) begin
                    if (line_s) begin
                        run_d = sat_inc7(run_q);
                    end else begin
                        // A fifth symbol only flags overflow; pattern keeps the first four.
                        if (count_q >= 3'd4) begin
                            ovf_d = 1'b1;
                        end else begin
                            pattern_d = {pattern_q[2:0], (run_q >= DASH_RUN)};
                        end
                        if (count_q != 3'd5) begin
                            count_d = count_q + 3'd1;
                        end
                        run_d   = 3'd1;
                        state_d = S_SPACE;
                    end
                end
            end
            S_SPACE: begin
                if (tick) begin
                    if (line_s) begin
                        state_d = S_MARK;
                        run_d   = 3'd1;
                    end else begin
                        run_d = sat_inc7(run_q);
                        // Decode on the gap tick so valid appears in the EMIT cycle.
                        if (run_d >= GAP_RUN) begin
                            state_d             = S_EMIT;
                            valid_d             = 1'b1;
                            {letter_d, error_d} = lookup(count_q, pattern_q, ovf_q);
                        end
                    end
                end
            end
            S_EMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset discards any partial letter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q     <= '0;
            state_q   <= S_IDLE;
            run_q     <= 3'd0;
            pattern_q <= 4'd0;
            count_q   <= 3'd0;
            ovf_q     <= 1'b0;
            letter_q  <= 3'd0;
            error_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            state_q   <= state_d;
            run_q     <= run_d;
            pattern_q <= pattern_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            letter_q  <= letter_d;
            error_q   <= error_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign letter = letter_q;
    assign valid  = valid_q;
    assign error  = error_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_morse_rx.sv
// Testbench for morse_rx: scoreboard of expected letters from a symbol-string
// reference model, two instances (1 and 3 clock cycles per unit).
module tb_morse_rx;

    localparam int DASH = 2;
    localparam int GAP  = 4;

    typedef int iq_t[$];
    typedef struct {
        logic [2:0] letter;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       line1 = 1'b0;
    logic       line3 = 1'b0;
    logic [2:0] letter1, letter3;
    logic       valid1, valid3, error1, error3, busy1, busy3;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rst_cyc = 0;
    bit   done = 1'b0;
    exp_t q1[$];
    exp_t q3[$];
    string tbl[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    morse_rx #(.UNIT_CYCLES(1), .DASH_MIN(DASH), .GAP_UNITS(GAP)) dut1 (
        .clk(clk), .resetn(resetn), .line(line1),
        .letter(letter1), .valid(valid1), .error(error1), .busy(busy1)
    );

    morse_rx #(.UNIT_CYCLES(3), .DASH_MIN(DASH), .GAP_UNITS(GAP)) dut3 (
        .clk(clk), .resetn(resetn), .line(line3),
        .letter(letter3), .valid(valid3), .error(error3), .busy(busy3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Marks as a dot/dash string, then a table lookup of the Morse letters A..H.
    function automatic void ref_decode(input iq_t marks, output logic [2:0] l, output logic e);
        string s;
        string sym;
        s = "";
        foreach (marks[i]) begin
            sym = (marks[i] >= DASH) ? "-" : ".";
            s = {s, sym};
        end
        l = 3'd0;
        e = 1'b1;
        if (marks.size() <= 4) begin
            for (int k = 0; k < 8; k++) begin
                if (s == tbl[k]) begin
                    l = 3'(k);
                    e = 1'b0;
                end
            end
        end
    endfunction

    function automatic iq_t mk(input int a, input int b = 0, input int c = 0,
                               input int d = 0, input int e = 0);
        iq_t q;
        q = {};
        if (a > 0) q.push_back(a);
        if (b > 0) q.push_back(b);
        if (c > 0) q.push_back(c);
        if (d > 0) q.push_back(d);
        if (e > 0) q.push_back(e);
        return q;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One unit = one clock on dut1; sp=0 picks random inter-symbol spaces.
    task automatic send1(input iq_t marks, input int sp);
        exp_t x;
        int   s;
        for (int i = 0; i < marks.size(); i++) begin
            for (int u = 0; u < marks[i]; u++) begin
                line1 = 1'b1;
                @(negedge clk);
                if (i == 0 && u == 0) chk("busy1_rise", int'(busy1), 1);
            end
            if (i != marks.size() - 1) begin
                s = (sp == 0) ? int'($urandom_range(GAP - 1, 1)) : sp;
                repeat (s) begin
                    line1 = 1'b0;
                    @(negedge clk);
                end
            end
        end
        ref_decode(marks, x.letter, x.err);
        x.cyc = cyc + GAP;
        q1.push_back(x);
        repeat (GAP + int'($urandom_range(3, 1))) begin
            line1 = 1'b0;
            @(negedge clk);
        end
        chk("busy1_idle", int'(busy1), 0);
    endtask

    // One unit = three clocks on dut3; spaces of 2 units, gap of 6 units.
    task automatic send3(input iq_t marks);
        exp_t x;
        ref_decode(marks, x.letter, x.err);
        x.cyc = -1;
        q3.push_back(x);
        for (int i = 0; i < marks.size(); i++) begin
            repeat (marks[i] * 3) begin
                line3 = 1'b1;
                @(negedge clk);
            end
            if (i != marks.size() - 1) begin
                repeat (6) begin
                    line3 = 1'b0;
                    @(negedge clk);
                end
            end
        end
        repeat (18) begin
            line3 = 1'b0;
            @(negedge clk);
        end
        chk("busy3_idle", int'(busy3), 0);
    endtask

    initial begin
        fork
            // Monitor: pop and compare on every valid strobe.
            begin
                exp_t x;
                while (!done) begin
                    @(negedge clk);
                    if (valid1) begin
                        if (q1.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL dut1_unexpected_valid: got valid letter=%0d error=%0d, required none (cycle %0d)",
                                     letter1, error1, cyc);
                        end else begin
                            x = q1.pop_front();
                            chk("dut1_letter", int'(letter1), int'(x.letter));
                            chk("dut1_error", int'(error1), int'(x.err));
                            chk("dut1_valid_cycle", cyc, x.cyc);
                        end
                    end
                    if (valid3) begin
                        if (q3.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL dut3_unexpected_valid: got valid letter=%0d error=%0d, required none (cycle %0d)",
                                     letter3, error3, cyc);
                        end else begin
                            x = q3.pop_front();
                            chk("dut3_letter", int'(letter3), int'(x.letter));
                            chk("dut3_error", int'(error3), int'(x.err));
                        end
                    end
                end
            end
            // Stimulus.
            begin
                iq_t m;
                int  n;
                repeat (3) @(negedge clk);
                chk("rst_letter", int'(letter1), 0);
                chk("rst_valid", int'(valid1), 0);
                chk("rst_error", int'(error1), 0);
                chk("rst_busy", int'(busy1), 0);
                resetn  = 1'b1;
                rst_cyc = cyc;
                repeat (2) @(negedge clk);

                send1(mk(1, 3), 2);           // A
                send1(mk(1, 1, 1, 1), 2);     // H
                send1(mk(3, 1, 3, 1), 2);     // C
                send1(mk(3, 3, 3), 2);        // O: unrecognised
                send1(mk(10), 2);             // T with saturating run
                send1(mk(1, 1, 1, 1, 1), 2);  // overflow
                send1(mk(3, 1, 1), 1);        // D with 1-unit spaces

                // Reset during the space after a dash.
                repeat (3) begin line1 = 1'b1; @(negedge clk); end
                repeat (2) begin line1 = 1'b0; @(negedge clk); end
                chk("pre_reset_busy", int'(busy1), 1);
                resetn = 1'b0;
                @(negedge clk);
                chk("midrst_letter", int'(letter1), 0);
                chk("midrst_valid", int'(valid1), 0);
                chk("midrst_error", int'(error1), 0);
                chk("midrst_busy", int'(busy1), 0);
                resetn  = 1'b1;
                rst_cyc = cyc;
                repeat (8) @(negedge clk);
                chk("post_rst_busy", int'(busy1), 0);
                send1(mk(1), 2);              // E

                // Glitch on a non-tick sample of the 3-cycle prescaler.
                while (((cyc + 1 - rst_cyc) % 3) != 1) @(negedge clk);
                line3 = 1'b1;
                @(negedge clk);
                line3 = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("glitch_busy3", int'(busy3), 0);
                end
                repeat (20) @(negedge clk);

                send3(mk(1));                 // E
                send3(mk(3, 1, 1));           // D
                send3(mk(1, 1, 3, 1));        // F
                send3(mk(3, 3, 3));           // O: error

                // Randomised letters on dut1.
                for (int t = 0; t < 40; t++) begin
                    m = {};
                    n = int'($urandom_range(5, 1));
                    for (int k = 0; k < n; k++) begin
                        if ($urandom_range(9, 0) == 0) m.push_back(int'($urandom_range(12, 5)));
                        else m.push_back(int'($urandom_range(4, 1)));
                    end
                    send1(m, 0);
                end

                repeat (10) @(negedge clk);
                chk("q1_drained", q1.size(), 0);
                chk("q3_drained", q3.size(), 0);
                done = 1'b1;
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
